i8008_cpu: RTL and testbench

- Single-clock, one-state-per-clock implementation of a subset of the Intel 8008 8-bit microprocessor.
- Drives the multiplexed 8-bit bus as split D_in/D_out.
- Exposes the 3-bit processor state and a Sync strobe.
- Contains the register file A,B,C,D,E,H,L, the CZSP flags, a 14-bit PC, and an address stack.

---
 rtl/i8008_cpu.sv | 223 ++++++++++++++++++++++
 tb/tb_i8008_cpu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i8008_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i8008_cpu : one-state-per-clock Intel 8008 subset with split D bus   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module i8008_cpu #(
   parameter int WIDTH        = 8,
   parameter int STACK_HEIGHT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D_in,
   input  logic             INTR,
   input  logic             READY,
   output logic [WIDTH-1:0] D_out,
   output logic             Sync,
   output logic [2:0]       state
);

   localparam int SP_W = (STACK_HEIGHT > 1) ? $clog2(STACK_HEIGHT) : 1;
   localparam logic [1:0] PCI = 2'b00;
   localparam logic [1:0] PCR = 2'b01;
   localparam logic [1:0] PCW = 2'b11;

   typedef enum logic [2:0] {
      ST_WAIT    = 3'b000,
      ST_T2      = 3'b001,
      ST_T1      = 3'b010,
      ST_T1I     = 3'b011,
      ST_T3      = 3'b100,
      ST_T5      = 3'b101,
      ST_STOPPED = 3'b110,
      ST_T4      = 3'b111
   } state_t;

   state_t           cur;
   logic [SP_W-1:0]  sp;
   logic [13:0]      stack [0:STACK_HEIGHT-1];
   logic [WIDTH-1:0] regs [0:7];   // slot 7 is the M code and is never written
   logic [WIDTH-1:0] ir;
   logic [WIDTH-1:0] tmp_lo;
   logic [5:0]       tmp_hi;
   logic [1:0]       cyc;
   logic             int_ack;
   logic             flag_c, flag_z, flag_s, flag_p;

   logic [13:0]      pc, addr, target;
   logic [SP_W-1:0]  sp_inc, sp_dec;
   logic [2:0]       ddd, sss;
   logic             is_hlt, is_lri, is_lmi, is_alui, is_jmp, is_cal, is_ret, is_rst;
   logic             is_inr, is_dcr, is_rot, is_alur, is_mov, mem_rd, mem_wr;
   logic             wr_cycle, use_hl, pc_addressed, d_hlt;
   logic [1:0]       last_cyc, ctype;
   logic [WIDTH-1:0] src, alu_b, wr_data, incdec, rot_res;
   logic [WIDTH:0]   alu_res;
   logic             rot_c;

   assign pc     = stack[sp];
   assign sp_inc = (sp == SP_W'(STACK_HEIGHT - 1)) ? '0 : sp + SP_W'(1);
   assign sp_dec = (sp == '0) ? SP_W'(STACK_HEIGHT - 1) : sp - SP_W'(1);
   assign ddd    = ir[5:3];
   assign sss    = ir[2:0];
   assign target = {tmp_hi, tmp_lo};

   assign is_hlt  = (ir == 8'h00) || (ir == 8'h01) || (ir == 8'hFF);
   assign is_lri  = (ir[7:6] == 2'b00) && (sss == 3'b110);
   assign is_lmi  = is_lri && (ddd == 3'd7);
   assign is_alui = (ir[7:6] == 2'b00) && (sss == 3'b100);
   assign is_jmp  = (ir[7:6] == 2'b01) && (sss == 3'b100);
   assign is_cal  = (ir[7:6] == 2'b01) && (sss == 3'b110);
   assign is_ret  = (ir[7:6] == 2'b00) && (sss == 3'b111);
   assign is_rst  = (ir[7:6] == 2'b00) && (sss == 3'b101);
   assign is_inr  = (ir[7:6] == 2'b00) && (sss == 3'b000) && (ddd != 3'd0) && (ddd != 3'd7);
   assign is_dcr  = (ir[7:6] == 2'b00) && (sss == 3'b001) && (ddd != 3'd0) && (ddd != 3'd7);
   assign is_rot  = (ir[7:6] == 2'b00) && (sss == 3'b010) && !ddd[2];
   assign is_alur = (ir[7:6] == 2'b10);
   assign is_mov  = (ir[7:6] == 2'b11) && !is_hlt;
   assign mem_rd  = (is_alur && sss == 3'd7) || (is_mov && sss == 3'd7);
   assign mem_wr  = is_mov && (ddd == 3'd7);

   assign last_cyc = (is_jmp || is_cal || is_lmi) ? 2'd2 :
                     ((is_lri || is_alui || mem_rd || mem_wr) ? 2'd1 : 2'd0);

   // Cycle 0 is always the PC fetch; later cycles go to H:L only for M operands.
   assign wr_cycle     = (mem_wr && cyc == 2'd1) || (is_lmi && cyc == 2'd2);
   assign use_hl       = (cyc != 2'd0) && (wr_cycle || mem_rd);
   assign pc_addressed = (cyc == 2'd0) ? !int_ack : !use_hl;
   assign ctype        = (cyc == 2'd0) ? PCI : (wr_cycle ? PCW : PCR);
   assign addr         = use_hl ? {regs[5][5:0], regs[6]} : pc;
   assign d_hlt        = (D_in == 8'h00) || (D_in == 8'h01) || (D_in == 8'hFF);

   assign src     = (sss == 3'd7) ? tmp_lo : regs[sss];
   assign alu_b   = is_alui ? tmp_lo : src;
   assign wr_data = is_lmi ? tmp_lo : regs[sss];
   assign incdec  = sss[0] ? regs[ddd] - WIDTH'(1) : regs[ddd] + WIDTH'(1);

   always_comb begin
      alu_res = '0;
      case (ddd)
         3'd0:    alu_res = {1'b0, regs[0]} + {1'b0, alu_b};
         3'd1:    alu_res = {1'b0, regs[0]} + {1'b0, alu_b} + {{WIDTH{1'b0}}, flag_c};
         3'd2:    alu_res = {1'b0, regs[0]} - {1'b0, alu_b};
         3'd3:    alu_res = {1'b0, regs[0]} - {1'b0, alu_b} - {{WIDTH{1'b0}}, flag_c};
         3'd4:    alu_res = {1'b0, regs[0] & alu_b};
         3'd5:    alu_res = {1'b0, regs[0] ^ alu_b};
         3'd6:    alu_res = {1'b0, regs[0] | alu_b};
         default: alu_res = {1'b0, regs[0]} - {1'b0, alu_b};
      endcase
   end

   always_comb begin
      rot_res = regs[0];
      rot_c   = flag_c;
      case (ddd[1:0])
         2'd0: begin rot_res = {regs[0][WIDTH-2:0], regs[0][WIDTH-1]}; rot_c = regs[0][WIDTH-1]; end
         2'd1: begin rot_res = {regs[0][0], regs[0][WIDTH-1:1]};       rot_c = regs[0][0];       end
         2'd2: begin rot_res = {regs[0][WIDTH-2:0], flag_c};           rot_c = regs[0][WIDTH-1]; end
         default: begin rot_res = {flag_c, regs[0][WIDTH-1:1]};       rot_c = regs[0][0];       end
      endcase
   end

   always_comb begin
      D_out = '0;
      case (cur)
         ST_T1, ST_T1I: D_out = addr[7:0];
         ST_T2:         D_out = {ctype, addr[13:8]};
         ST_T3:         if (ctype == PCW) D_out = wr_data;
         default:       D_out = '0;
      endcase
   end

   assign state = cur;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur     <= ST_T1;
         Sync    <= 1'b1;
         sp      <= '0;
         cyc     <= 2'd0;
         ir      <= '0;
         tmp_lo  <= '0;
         tmp_hi  <= '0;
         int_ack <= 1'b0;
         flag_c  <= 1'b0;
         flag_z  <= 1'b0;
         flag_s  <= 1'b0;
         flag_p  <= 1'b0;
         for (int i = 0; i < STACK_HEIGHT; i++) stack[i] <= '0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         Sync <= 1'b0;
         case (cur)
            ST_T1, ST_T1I: cur <= ST_T2;
            ST_T2, ST_WAIT: cur <= READY ? ST_T3 : ST_WAIT;
            ST_T3: begin
               if (pc_addressed) stack[sp] <= pc + 14'd1;
               if (cyc == 2'd0) begin
                  ir  <= D_in;
                  cur <= d_hlt ? ST_STOPPED : ST_T4;
               end else begin
                  if (ctype != PCW) begin
                     if (cyc == 2'd1) tmp_lo <= D_in;
                     else             tmp_hi <= D_in[5:0];
                  end
                  cur <= ST_T4;
               end
            end
            ST_T4: cur <= ST_T5;
            ST_T5: begin
               Sync <= 1'b1;
               if (cyc == last_cyc) begin
                  cyc     <= 2'd0;
                  int_ack <= INTR;
                  cur     <= INTR ? ST_T1I : ST_T1;
                  if (is_jmp) begin
                     stack[sp] <= target;
                  end else if (is_cal) begin
                     sp            <= sp_inc;
                     stack[sp_inc] <= target;
                  end else if (is_ret) begin
                     sp <= sp_dec;
                  end else if (is_rst) begin
                     sp            <= sp_inc;
                     stack[sp_inc] <= {8'd0, ddd, 3'b000};
                  end else if (is_lri && !is_lmi) begin
                     regs[ddd] <= tmp_lo;
                  end else if (is_mov && ddd != 3'd7) begin
                     regs[ddd] <= src;
                  end else if (is_alur || is_alui) begin
                     if (ddd != 3'd7) regs[0] <= alu_res[WIDTH-1:0];
                     flag_c <= alu_res[WIDTH];
                     flag_z <= (alu_res[WIDTH-1:0] == '0);
                     flag_s <= alu_res[WIDTH-1];
                     flag_p <= ~^alu_res[WIDTH-1:0];
                  end else if (is_inr || is_dcr) begin
                     regs[ddd] <= incdec;
                     flag_z    <= (incdec == '0);
                     flag_s    <= incdec[WIDTH-1];
                     flag_p    <= ~^incdec;
                  end else if (is_rot) begin
                     regs[0] <= rot_res;
                     flag_c  <= rot_c;
                  end
               end else begin
                  cyc <= cyc + 2'd1;
                  cur <= ST_T1;
               end
            end
            ST_STOPPED: begin
               if (INTR) begin
                  cur     <= ST_T1I;
                  cyc     <= 2'd0;
                  int_ack <= 1'b1;
                  Sync    <= 1'b1;
               end
            end
            default: cur <= ST_T1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i8008_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i8008_cpu : directed self-checking bench for i8008_cpu            |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_i8008_cpu;

   localparam logic [2:0] S_WAIT = 3'b000, S_T2 = 3'b001, S_T1 = 3'b010, S_T1I = 3'b011;
   localparam logic [2:0] S_T3 = 3'b100, S_T5 = 3'b101, S_STOP = 3'b110, S_T4 = 3'b111;

   logic       clk = 1'b0;
   logic       rst;
   logic       intr;
   logic       ready;
   logic [7:0] d_in = 8'h00;
   logic [7:0] d_out;
   logic       sync;
   logic [2:0] state;

   logic [7:0] mem [0:16383];
   logic [7:0] intr_byte = 8'h00;
   logic [7:0] a_lo = 8'h00;
   logic [5:0] a_hi = 6'h00;
   logic [1:0] ct = 2'b00;
   logic       ack = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   i8008_cpu #(.WIDTH(8), .STACK_HEIGHT(8)) dut (
      .clk(clk), .rst(rst), .D_in(d_in), .INTR(intr), .READY(ready),
      .D_out(d_out), .Sync(sync), .state(state)
   );

   always #5 clk = ~clk;

   // Memory responder: latch the address from T1/T2, answer reads, capture writes.
   always @(negedge clk) begin
      if (state == S_T1 || state == S_T1I) begin
         a_lo = d_out;
         ack  = (state == S_T1I);
      end
      if (state == S_T2) begin
         a_hi = d_out[5:0];
         ct   = d_out[7:6];
      end
      if (state == S_T2 || state == S_WAIT || state == S_T3)
         d_in = (ack && ct == 2'b00) ? intr_byte : mem[{a_hi, a_lo}];
      if (state == S_T3 && ct == 2'b11)
         mem[{a_hi, a_lo}] = d_out;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         found = (state == s);
      end
      n_checks++;
      assert (found) else begin
         n_fail++;
         $error("FAIL %s: observed timeout expected state %b", tag, s);
      end
   endtask

   task automatic wait_fetch(input logic [13:0] a, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         found = (state == S_T1 || state == S_T1I) && (dut.cyc == 2'd0) && (dut.pc == a);
      end
      n_checks++;
      assert (found) else begin
         n_fail++;
         $error("FAIL %s: observed timeout expected fetch at %h", tag, a);
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      // INB, DCE, LAI 05, RRC, ADC C, RAR, ADD C, HLT (standard register codes)
      mem[0] = 8'h08; mem[1] = 8'h21; mem[2] = 8'h06; mem[3] = 8'h05;
      mem[4] = 8'h0A; mem[5] = 8'h8A; mem[6] = 8'h1A; mem[7] = 8'h82;
      mem[8] = 8'h00;

      rst = 1'b1; intr = 1'b0; ready = 1'b0;
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_state", 16'(state), 16'(S_T1));
      chk("rst_dout",  16'(d_out), 16'h00);
      chk("rst_sync",  16'(sync), 16'h1);
      chk("rst_pc",    16'(dut.pc), 16'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("t2_state", 16'(state), 16'(S_T2));
      chk("t2_dout",  16'(d_out), 16'h00);
      chk("t2_sync",  16'(sync), 16'h0);
      @(negedge clk);
      chk("wait1", 16'(state), 16'(S_WAIT));
      @(negedge clk);
      chk("wait2", 16'(state), 16'(S_WAIT));
      chk("wait_dout", 16'(d_out), 16'h00);
      ready = 1'b1;
      @(negedge clk); chk("t3_state", 16'(state), 16'(S_T3));
      @(negedge clk); chk("t4_state", 16'(state), 16'(S_T4));
      @(negedge clk); chk("t5_state", 16'(state), 16'(S_T5));
      @(negedge clk);
      chk("t1_state", 16'(state), 16'(S_T1));
      chk("t1_dout",  16'(d_out), 16'h01);
      chk("t1_sync",  16'(sync), 16'h1);

      wait_fetch(14'd2, "to_lai");
      chk("inb_b", 16'(dut.regs[1]), 16'h01);
      chk("dce_e", 16'(dut.regs[4]), 16'hFF);
      chk("dce_z", 16'(dut.flag_z), 16'h0);
      chk("dce_s", 16'(dut.flag_s), 16'h1);
      chk("dce_p", 16'(dut.flag_p), 16'h1);
      wait_state(S_T2, "lai_fetch_t2");
      chk("fetch_t2_type", 16'(d_out), 16'h00);
      wait_state(S_T2, "lai_imm_t2");
      chk("lri_t2_type", 16'(d_out[7:6]), 16'h1);
      chk("lri_t2_dout", 16'(d_out), 16'h40);

      wait_fetch(14'd4, "to_rrc");
      chk("lai_a", 16'(dut.regs[0]), 16'h05);
      wait_fetch(14'd5, "to_adc");
      chk("rrc_a", 16'(dut.regs[0]), 16'h82);
      chk("rrc_c", 16'(dut.flag_c), 16'h1);
      wait_fetch(14'd6, "to_rar");
      chk("adc_a", 16'(dut.regs[0]), 16'h83);
      chk("adc_c", 16'(dut.flag_c), 16'h0);
      wait_fetch(14'd7, "to_add");
      chk("rar_a", 16'(dut.regs[0]), 16'h41);
      chk("rar_c", 16'(dut.flag_c), 16'h1);
      wait_fetch(14'd8, "to_hlt");
      chk("add_a", 16'(dut.regs[0]), 16'h41);
      chk("add_flags", {12'd0, dut.flag_c, dut.flag_z, dut.flag_s, dut.flag_p}, 16'h0001);

      wait_state(S_STOP, "to_stop");
      repeat (4) @(negedge clk);
      chk("stop_hold", 16'(state), 16'(S_STOP));
      chk("stop_dout", 16'(d_out), 16'h00);
      chk("stop_sync", 16'(sync), 16'h0);
      chk("stop_pc",   16'(dut.pc), 16'h0009);

      // Second program: CAL 0123, then LAI/LLI/LHI, LMA, SUI, LBM, JMP-to-self
      mem[0]  = 8'h46; mem[1]  = 8'h23; mem[2]  = 8'h01;
      mem[3]  = 8'h06; mem[4]  = 8'h5A; mem[5]  = 8'h36; mem[6]  = 8'h40;
      mem[7]  = 8'h2E; mem[8]  = 8'h00; mem[9]  = 8'hF8;
      mem[10] = 8'h14; mem[11] = 8'h5B; mem[12] = 8'hCF;
      mem[13] = 8'h44; mem[14] = 8'h0D; mem[15] = 8'h00;
      mem[14'h123] = 8'h07;
      intr_byte = 8'h05;
      intr = 1'b1;
      @(negedge clk);
      chk("t1i_state", 16'(state), 16'(S_T1I));
      chk("t1i_sync",  16'(sync), 16'h1);
      chk("t1i_dout",  16'(d_out), 16'h09);
      intr = 1'b0;
      wait_fetch(14'd0, "rst0_vector");
      chk("rst0_dout",  16'(d_out), 16'h00);
      chk("rst0_sp",    16'(dut.sp), 16'h1);
      chk("rst0_saved", 16'(dut.stack[0]), 16'h0009);

      wait_fetch(14'h123, "cal_target");
      chk("cal_sp",  16'(dut.sp), 16'h2);
      chk("cal_ret", 16'(dut.stack[1]), 16'h0003);
      chk("cal_dout", 16'(d_out), 16'h23);
      wait_fetch(14'd3, "ret_resume");
      chk("ret_sp",   16'(dut.sp), 16'h1);
      chk("ret_dout", 16'(d_out), 16'h03);

      wait_fetch(14'd9, "to_lma");
      chk("lhl", {dut.regs[5], dut.regs[6]}, 16'h0040);
      wait_state(S_T2, "lma_fetch_t2");
      wait_state(S_T2, "lma_wr_t2");
      chk("pcw_t2", 16'(d_out), 16'h00C0);
      wait_state(S_T3, "lma_wr_t3");
      chk("pcw_data", 16'(d_out), 16'h005A);
      wait_fetch(14'd10, "to_sui");
      chk("mem_written", 16'(mem[14'h040]), 16'h005A);
      wait_fetch(14'd12, "to_lbm");
      chk("sui_a", 16'(dut.regs[0]), 16'h00FF);
      chk("sui_flags", {12'd0, dut.flag_c, dut.flag_z, dut.flag_s, dut.flag_p}, 16'h000B);
      wait_fetch(14'd13, "to_jmp");
      chk("lbm_b", 16'(dut.regs[1]), 16'h005A);
      wait_state(S_T3, "jmp_busy");
      wait_fetch(14'd13, "jmp_loop");

      wait_state(S_T4, "mid_cycle");
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_state", 16'(state), 16'(S_T1));
      chk("mid_rst_pc",    16'(dut.pc), 16'h0);
      chk("mid_rst_sp",    16'(dut.sp), 16'h0);
      chk("mid_rst_a",     16'(dut.regs[0]), 16'h0);
      chk("mid_rst_b",     16'(dut.regs[1]), 16'h0);
      chk("mid_rst_sync",  16'(sync), 16'h1);
      chk("mid_rst_dout",  16'(d_out), 16'h0);
      @(negedge clk);
      rst = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
